// File: rtl/memoria_instrucciones_cargable_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Lane 0 of a fetched word is the byte at the lowest address and lands in the MSBs.
package mem_inst_pkg;

  typedef enum logic {
    LIBRE = 1'b0,
    CARGA = 1'b1
  } estado_e;

  localparam int unsigned WORD_BYTES = 4;

  localparam bit BIG_ENDIAN = 1'b1;

  function automatic int unsigned lane_shift(input int unsigned lane);
    return BIG_ENDIAN ? 8 * (WORD_BYTES - 1 - lane) : 8 * lane;
  endfunction

endpackage

// File: rtl/memoria_instrucciones_cargable_if.sv
// Fetch and loader signals of the instruction memory.
// master = fetch stage / boot loader, slave = memory.
interface memoria_instrucciones_cargable_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              req;
  logic [ADDR_W-1:0] dir;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              desalineado;
  logic              ocupado;
  logic              carga_inicio;
  logic [ADDR_W-1:0] carga_dir;
  logic              carga_valid;
  logic [7:0]        carga_byte;
  logic              carga_fin;
  logic [ADDR_W:0]   carga_cuenta;

  modport master (
    output req, dir, carga_inicio, carga_dir, carga_valid, carga_byte, carga_fin,
    input  inst, inst_valid, desalineado, ocupado, carga_cuenta
  );

  modport slave (
    input  req, dir, carga_inicio, carga_dir, carga_valid, carga_byte, carga_fin,
    output inst, inst_valid, desalineado, ocupado, carga_cuenta
  );

endinterface

// File: rtl/memoria_instrucciones_cargable_banco_bytes.sv
// Unreset byte array: one synchronous write port, four combinational read taps
// at rdir+0..3 wrapping modulo the depth, assembled big-endian.
module banco_bytes
  import mem_inst_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wdir,
  input  logic [7:0]        wdato,
  input  logic [ADDR_W-1:0] rdir,
  output logic [31:0]       rpalabra
);

  logic [7:0] mem [0:2**ADDR_W-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wdir] <= wdato;
    end
  end

  always_comb begin
    rpalabra = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      rpalabra[lane_shift(i) +: 8] = mem[rdir + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/memoria_instrucciones_cargable.sv
// Byte-addressed instruction memory with a registered one-cycle fetch port
// and a byte-serial loader that owns the array while in CARGA.
module memoria_instrucciones_cargable
  import mem_inst_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input logic                           clk,
  input logic                           rst,
  memoria_instrucciones_cargable_if.slave bus
);

  localparam logic [ADDR_W:0] CUENTA_MAX = {1'b1, {ADDR_W{1'b0}}};

  estado_e           estado_q, estado_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cuenta_q, cuenta_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              desal_q, desal_d;

  logic              we;
  logic [31:0]       palabra;

  assign we = (estado_q == CARGA) && bus.carga_valid;

  banco_bytes #(
    .ADDR_W(ADDR_W)
  ) u_banco (
    .clk      (clk),
    .we       (we),
    .wdir     (ptr_q),
    .wdato    (bus.carga_byte),
    .rdir     (bus.dir),
    .rpalabra (palabra)
  );

  always_comb begin
    estado_d     = estado_q;
    ptr_d        = ptr_q;
    cuenta_d     = cuenta_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    desal_d      = 1'b0;

    unique case (estado_q)
      LIBRE: begin
        if (bus.carga_inicio) begin
          estado_d = CARGA;
          ptr_d    = bus.carga_dir;
          cuenta_d = '0;
        end else if (bus.req) begin
          inst_valid_d = 1'b1;
          if (ALIGN_CHECK && (bus.dir[1:0] != 2'b00)) begin
            inst_d  = '0;
            desal_d = 1'b1;
          end else begin
            inst_d = palabra;
          end
        end
      end
      CARGA: begin
        // The byte on carga_valid lands at the old pointer even when a restart
        // or the end of the session is sampled in the same cycle.
        if (bus.carga_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (cuenta_q != CUENTA_MAX) begin
            cuenta_d = cuenta_q + 1'b1;
          end
        end
        if (bus.carga_inicio) begin
          ptr_d    = bus.carga_dir;
          cuenta_d = '0;
        end else if (bus.carga_fin) begin
          estado_d = LIBRE;
        end
      end
      default: estado_d = LIBRE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= LIBRE;
      ptr_q        <= '0;
      cuenta_q     <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      desal_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      ptr_q        <= ptr_d;
      cuenta_q     <= cuenta_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      desal_q      <= desal_d;
    end
  end

  assign bus.inst         = inst_q;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.desalineado  = desal_q;
  assign bus.ocupado      = (estado_q == CARGA);
  assign bus.carga_cuenta = cuenta_q;

endmodule

// File: tb/tb_memoria_instrucciones_cargable.sv
// Scoreboard bench: two instances (ALIGN_CHECK=1 and 0) share one stimulus
// stream; per-instance queues hold expected fetch responses.
module tb_memoria_instrucciones_cargable;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] mask;
    logic        desal;
  } esp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       req = 1'b0;
  logic [7:0] dir = '0;
  logic       carga_inicio = 1'b0;
  logic [7:0] carga_dir = '0;
  logic       carga_valid = 1'b0;
  logic [7:0] carga_byte = '0;
  logic       carga_fin = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;
  esp_t q_a[$];
  esp_t q_b[$];

  always #5 clk = ~clk;

  memoria_instrucciones_cargable_if #(.ADDR_W(8)) bus_a ();
  memoria_instrucciones_cargable_if #(.ADDR_W(8)) bus_b ();

  assign bus_a.req = req;                   assign bus_b.req = req;
  assign bus_a.dir = dir;                   assign bus_b.dir = dir;
  assign bus_a.carga_inicio = carga_inicio; assign bus_b.carga_inicio = carga_inicio;
  assign bus_a.carga_dir = carga_dir;       assign bus_b.carga_dir = carga_dir;
  assign bus_a.carga_valid = carga_valid;   assign bus_b.carga_valid = carga_valid;
  assign bus_a.carga_byte = carga_byte;     assign bus_b.carga_byte = carga_byte;
  assign bus_a.carga_fin = carga_fin;       assign bus_b.carga_fin = carga_fin;

  memoria_instrucciones_cargable #(.ADDR_W(8), .ALIGN_CHECK(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  memoria_instrucciones_cargable #(.ADDR_W(8), .ALIGN_CHECK(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", nombre, act, exp);
    end
  endtask

  // Monitor: every response presented by a DUT must match the oldest expectation.
  always @(negedge clk) begin
    esp_t e;
    if (!rst && bus_a.inst_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("A unexpected inst_valid", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("A inst", bus_a.inst & e.mask, e.inst & e.mask);
        chk("A desalineado", {31'd0, bus_a.desalineado}, {31'd0, e.desal});
      end
    end
    if (!rst && bus_b.inst_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("B unexpected inst_valid", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("B inst", bus_b.inst & e.mask, e.inst & e.mask);
        chk("B desalineado", {31'd0, bus_b.desalineado}, {31'd0, e.desal});
      end
    end
  end

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic iniciar(input logic [7:0] d);
    carga_inicio = 1'b1;
    carga_dir    = d;
    ciclo();
    carga_inicio = 1'b0;
  endtask

  task automatic escribir(input logic [7:0] b, input logic fin);
    carga_valid = 1'b1;
    carga_byte  = b;
    carga_fin   = fin;
    ciclo();
    carga_valid = 1'b0;
    carga_fin   = 1'b0;
  endtask

  task automatic terminar();
    carga_fin = 1'b1;
    ciclo();
    carga_fin = 1'b0;
  endtask

  task automatic pedir(input logic [7:0] d, input logic [31:0] ia, input logic da,
                       input logic [31:0] ib, input logic db, input logic [31:0] m);
    q_a.push_back('{inst: ia, mask: m, desal: da});
    q_b.push_back('{inst: ib, mask: m, desal: db});
    req = 1'b1;
    dir = d;
    ciclo();
    req = 1'b0;
  endtask

  task automatic chk_cuenta(input string nombre, input logic [8:0] exp);
    chk({nombre, " A cuenta"}, {23'd0, bus_a.carga_cuenta}, {23'd0, exp});
    chk({nombre, " B cuenta"}, {23'd0, bus_b.carga_cuenta}, {23'd0, exp});
  endtask

  task automatic chk_ocupado(input string nombre, input logic exp);
    chk({nombre, " A ocupado"}, {31'd0, bus_a.ocupado}, {31'd0, exp});
    chk({nombre, " B ocupado"}, {31'd0, bus_b.ocupado}, {31'd0, exp});
  endtask

  initial begin
    logic [7:0] prog [8];
    prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset inst", bus_a.inst, 32'h0);
    chk("reset inst_valid", {31'd0, bus_a.inst_valid}, 32'd0);
    chk("reset desalineado", {31'd0, bus_a.desalineado}, 32'd0);
    chk_ocupado("reset", 1'b0);
    chk_cuenta("reset", 9'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ciclo();

    // Aligned load and back-to-back fetch
    iniciar(8'h00);
    chk_ocupado("after inicio", 1'b1);
    for (int i = 0; i < 8; i++) escribir(prog[i], 1'b0);
    terminar();
    chk_ocupado("after fin", 1'b0);
    chk_cuenta("load 8", 9'd8);
    pedir(8'h00, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 32'hFFFFFFFF);
    pedir(8'h04, 32'hAABBCCDD, 1'b0, 32'hAABBCCDD, 1'b0, 32'hFFFFFFFF);
    pedir(8'h02, 32'h00000000, 1'b1, 32'h5678AABB, 1'b0, 32'hFFFFFFFF);
    ciclo();

    // Wrap-around load at the top of memory
    iniciar(8'hFE);
    escribir(8'h11, 1'b0);
    escribir(8'h22, 1'b0);
    escribir(8'h33, 1'b0);
    escribir(8'h44, 1'b0);
    terminar();
    chk_cuenta("wrap load", 9'd4);
    pedir(8'hFE, 32'h00000000, 1'b1, 32'h11223344, 1'b0, 32'hFFFFFFFF);
    pedir(8'h00, 32'h33445678, 1'b0, 32'h33445678, 1'b0, 32'hFFFFFFFF);
    ciclo();

    // Fetches dropped while the loader owns the memory
    req = 1'b1; dir = 8'h00; carga_inicio = 1'b1; carga_dir = 8'h10;
    ciclo();
    carga_inicio = 1'b0;
    chk_ocupado("inicio with req", 1'b1);
    ciclo();
    req = 1'b0;
    escribir(8'h01, 1'b0);
    escribir(8'h02, 1'b0);
    escribir(8'h03, 1'b0);
    escribir(8'h04, 1'b1);
    chk_ocupado("valid with fin", 1'b0);
    chk_cuenta("valid with fin", 9'd4);
    pedir(8'h10, 32'h01020304, 1'b0, 32'h01020304, 1'b0, 32'hFFFFFFFF);
    ciclo();

    // Reset aborts a session mid-load; written bytes survive
    iniciar(8'h20);
    escribir(8'hA1, 1'b0);
    escribir(8'hB2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_ocupado("rst mid-load", 1'b0);
    chk_cuenta("rst mid-load", 9'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ciclo();
    pedir(8'h20, 32'hA1B20000, 1'b0, 32'hA1B20000, 1'b0, 32'hFFFF0000);
    ciclo();

    // Counter saturates at 256 while the pointer keeps wrapping
    iniciar(8'h00);
    for (int i = 0; i < 257; i++) escribir(8'(i), 1'b0);
    chk_cuenta("saturate", 9'd256);
    terminar();
    chk_cuenta("saturate after fin", 9'd256);
    pedir(8'h04, 32'h04050607, 1'b0, 32'h04050607, 1'b0, 32'hFFFFFFFF);
    pedir(8'hFC, 32'hFCFDFEFF, 1'b0, 32'hFCFDFEFF, 1'b0, 32'hFFFFFFFF);
    pedir(8'h01, 32'h00000000, 1'b1, 32'h01020304, 1'b0, 32'hFFFFFFFF);

    // Bounded drain: any expectation still queued is a missing response
    repeat (4) ciclo();
    chk("A pending responses", q_a.size(), 32'd0);
    chk("B pending responses", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memoria_instrucciones_cargable.md
# memoria_instrucciones_cargable

Parametrised, byte-addressed, big-endian instruction memory with a registered fetch port and a byte-serial loader port. The fetch side serves the MIPS fetch stage: one word per request, one-cycle latency, with optional misalignment checking. The loader side lets a testbench or boot controller write program bytes at run time without `initial` blocks. It replaces the combinational, fixed-size instruction memory in the datapath.

## Interface
- `ADDR_W`, 8: byte-address width; depth is 2**ADDR_W bytes.
- `ALIGN_CHECK`, 1: 1 = flag fetches with `dir[1:0]!=0`; 0 = serve unaligned fetches.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 1: fetch request, sampled at the rising edge.
- `dir` input ADDR_W: fetch byte address.
- `inst` output 32: fetched word, big-endian: {mem[dir], mem[dir+1], mem[dir+2], mem[dir+3]}.
- `inst_valid` output 1: one-cycle pulse; `inst`/`desalineado` are valid.
- `desalineado` output 1: misaligned-fetch error, qualified by `inst_valid`.
- `ocupado` output 1: high while the loader owns the memory.
- `carga_inicio` input 1: start a load session at `carga_dir`.
- `carga_dir` input ADDR_W: load start address.
- `carga_valid` input 1: `carga_byte` is valid this cycle.
- `carga_byte` input 8: byte to write.
- `carga_fin` input 1: end the load session.
- `carga_cuenta` output ADDR_W+1: bytes written in the current or last session; saturates at 2**ADDR_W.

## Operation
- FSM states:
  - LIBRE: fetches are accepted.
  - CARGA: loader owns the memory; `ocupado`=1.
- LIBRE → CARGA on `carga_inicio`:
  - Loader pointer ← `carga_dir`.
  - `carga_cuenta` ← 0.
  - `carga_inicio` has priority: a `req` in the same cycle is dropped (no `inst_valid`).
- In CARGA, each `carga_valid` cycle:
  - mem[pointer] ← `carga_byte`.
  - Pointer increments modulo 2**ADDR_W (wraps 0xFF→0x00 for ADDR_W=8).
  - `carga_cuenta` increments, saturating.
- CARGA → LIBRE on `carga_fin`. If `carga_valid` is high in the same cycle, the byte is written first.
- `carga_inicio` while in CARGA restarts the session: new pointer, count reset.
- `req` in CARGA is ignored: no response, no queuing. The requester must watch `ocupado`.
- Fetch in LIBRE:
  - With `ALIGN_CHECK`=1 and `dir[1:0]`≠0: `inst`=0, `desalineado`=1, `inst_valid`=1.
  - Otherwise: the 4 bytes at dir..dir+3, each address modulo 2**ADDR_W (wraps at the top of memory).
- Memory array is not reset. Contents are X until loaded and survive `rst`.

## Timing
- Fetch latency is 1 cycle: `req` sampled at edge N → `inst_valid`, `inst`, `desalineado` valid after edge N, until edge N+1.
- Throughput is one fetch per cycle; back-to-back requests are supported.
- `inst` holds its last value when `inst_valid`=0.
- `ocupado` is registered:
  - Rises the cycle after `carga_inicio` is sampled.
  - Falls the cycle after `carga_fin` is sampled.
- A write sampled at edge N is visible to a fetch sampled at edge N+1 or later.
- Reset (async assert, sync deassert by the system):
  - State ← LIBRE; pointer ← 0.
  - `inst_valid`=0, `desalineado`=0, `inst`=0, `ocupado`=0, `carga_cuenta`=0.
- Reset mid-load aborts the session. Bytes already written stay in memory.

## Structure
- Package `mem_inst_pkg`:
  - FSM state enum (LIBRE, CARGA).
  - `WORD_BYTES`=4.
  - Big-endian byte-lane ordering constant.
- Sub-module `banco_bytes`:
  - Plain byte array, 1 write port plus 4 combinational read taps at dir+0..3 with modulo wrap.
  - No reset.
- The top level holds the FSM, loader pointer, counter and output registers.

## Test plan
- Aligned load and fetch, ALIGN_CHECK=1:
  - Reset, then load 12 34 56 78 AA BB CC DD at 0x00, then `carga_fin`.
  - req dir=0x00 → next cycle `inst`=0x12345678, `inst_valid`=1.
  - req dir=0x04 (back-to-back) → `inst`=0xAABBCCDD.
  - `carga_cuenta`=8.
- Misaligned fetch, ALIGN_CHECK=1: req dir=0x02 → `inst_valid`=1, `desalineado`=1, `inst`=0.
- Wrap-around, ALIGN_CHECK=0:
  - Load 11 22 33 44 at 0xFE; pointer wraps.
  - req dir=0xFE → `inst`=0x11223344, `desalineado`=0.
  - mem[0x00]=0x33 (read back with req dir=0x00 → `inst`[31:24]=0x33).
- Fetch blocked during load:
  - req while `ocupado`=1 → no `inst_valid`.
  - `carga_inicio` and `req` in the same cycle → no response.
  - `carga_valid` and `carga_fin` in the same cycle → byte written, `ocupado` falls next cycle.
- Reset mid-load:
  - Assert `rst` after 2 of 4 bytes → `ocupado`=0, `carga_cuenta`=0 immediately.
  - The two written bytes read back intact after reset.
